// File: rtl/mem_port_if.sv
// -----------------------------------------------------------------------------
// mem_port_if
//   Word-organised 16-bit memory bus with byte enables and a request/acknowledge
//   handshake, as driven by mem_port.
//
//   Signals:
//     mem_req   master->slave  bus request, held until mem_ack
//     mem_we    master->slave  1 = write
//     mem_addr  master->slave  15-bit word address
//     mem_be    master->slave  byte enables, bit 1 = bits [15:8] (odd byte)
//     mem_wdata master->slave  write data
//     mem_rdata slave->master  read data, valid while mem_ack = 1
//     mem_ack   slave->master  completes the current request
// -----------------------------------------------------------------------------
interface mem_port_if;
    logic        mem_req;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_port.sv
// -----------------------------------------------------------------------------
// mem_port
//   Data-memory access stage. Turns the execute-phase strobes (rd_mem, wr_mem,
//   byt) plus byte address and store data into request/acknowledge beats on a
//   16-bit little-endian word bus, stalls the phase sequencer while a beat is
//   outstanding and returns load data (byte loads zero-extended).
//
//   Parameter:
//     TIMEOUT   cycles to wait for mem_ack in one beat before aborting (1..255)
//
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     rd_mem, wr_mem    access strobes (write wins when both are set)
//     byt               1 = byte access, 0 = word access
//     addr, wdata       byte address and store data
//     rdata             load result, held until the next read completes
//     stall             combinational, high from the start cycle to the last beat
//     bus_err           one-cycle pulse after a timeout abort
//     misalign          one-cycle pulse on an odd-address word access
//     bus               memory bus (mem_port_if.master)
//
//   Build option:
//     MEM_PORT_UNALIGNED_EN  when defined, odd-address word accesses are split
//                            into two beats and misalign stays 0; otherwise
//                            the address LSB is dropped for word accesses.
// -----------------------------------------------------------------------------
module mem_port #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_mem,
    input  logic        wr_mem,
    input  logic        byt,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        stall,
    output logic        bus_err,
    output logic        misalign,
    mem_port_if.master  bus
);

`ifdef MEM_PORT_UNALIGNED_EN
    localparam bit UNALIGNED = 1'b1;
`else
    localparam bit UNALIGNED = 1'b0;
`endif

    // The counter holds the number of further wait cycles allowed, so the
    // request stays up for exactly TIMEOUT cycles in one state.
    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic        byt_q, byt_d;
    logic        lane_q, lane_d;          // addr[0] of the access
    logic        split_q, split_d;
    logic [7:0]  wdata_hi_q, wdata_hi_d;  // store byte for the second beat
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] rbuf_q, rbuf_d;          // read data assembled across beats
    logic [15:0] rdata_q, rdata_d;
    logic        req_q, req_d;
    logic        bus_we_q, bus_we_d;
    logic [14:0] bus_addr_q, bus_addr_d;
    logic [1:0]  be_q, be_d;
    logic [15:0] bus_wdata_q, bus_wdata_d;
    logic        bus_err_q, bus_err_d;
    logic        misalign_q, misalign_d;

    logic start;
    logic in_acc;
    logic first_split;

    assign start       = rd_mem | wr_mem;
    assign in_acc      = (state_q == ACC1) || (state_q == ACC2);
    assign first_split = (state_q == ACC1) && split_q;

    // Gated by rst so the sequencer is released the instant reset hits, even
    // though the control side may still hold its strobes.
    assign stall = !rst && (((state_q == IDLE) && start) || in_acc);

    assign rdata         = rdata_q;
    assign bus_err       = bus_err_q;
    assign misalign      = misalign_q;
    assign bus.mem_req   = req_q;
    assign bus.mem_we    = bus_we_q;
    assign bus.mem_addr  = bus_addr_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = bus_wdata_q;

    always_comb begin
        // NOTE: every _d starts from its hold value so no path can infer a latch.
        state_d     = state_q;
        we_d        = we_q;
        byt_d       = byt_q;
        lane_d      = lane_q;
        split_d     = split_q;
        wdata_hi_d  = wdata_hi_q;
        cnt_d       = cnt_q;
        rbuf_d      = rbuf_q;
        rdata_d     = rdata_q;
        req_d       = req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        be_d        = be_q;
        bus_wdata_d = bus_wdata_q;
        bus_err_d   = 1'b0;
        misalign_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    we_d       = wr_mem;
                    byt_d      = byt;
                    lane_d     = addr[0];
                    split_d    = UNALIGNED && !byt && addr[0];
                    misalign_d = !UNALIGNED && !byt && addr[0];
                    wdata_hi_d = wdata[15:8];
                    cnt_d      = TMO_LOAD;
                    req_d      = 1'b1;
                    bus_we_d   = wr_mem;
                    bus_addr_d = addr[15:1];
                    if (byt) begin
                        be_d        = addr[0] ? 2'b10 : 2'b01;
                        bus_wdata_d = {wdata[7:0], wdata[7:0]};
                    end else if (UNALIGNED && addr[0]) begin
                        // Low store byte goes to the odd lane of the first word.
                        be_d        = 2'b10;
                        bus_wdata_d = {wdata[7:0], 8'h00};
                    end else begin
                        be_d        = 2'b11;
                        bus_wdata_d = wdata;
                    end
                    state_d = ACC1;
                end
            end

            ACC1, ACC2: begin
                if (bus.mem_ack) begin
                    if (first_split) begin
                        rbuf_d[7:0] = bus.mem_rdata[15:8];
                    end else if (state_q == ACC2) begin
                        rbuf_d[15:8] = bus.mem_rdata[7:0];
                    end else if (byt_q) begin
                        rbuf_d = {8'h00, lane_q ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0]};
                    end else begin
                        rbuf_d = bus.mem_rdata;
                    end

                    if (first_split) begin
                        // Second beat: next word (wraps at 2^15), even lane.
                        state_d     = ACC2;
                        cnt_d       = TMO_LOAD;
                        bus_addr_d  = bus_addr_q + 15'd1;
                        be_d        = 2'b01;
                        bus_wdata_d = {8'h00, wdata_hi_q};
                    end else begin
                        state_d  = DONE;
                        req_d    = 1'b0;
                        bus_we_d = 1'b0;
                        be_d     = 2'b00;
                    end
                end else if (cnt_q == 8'd0) begin
                    state_d   = DONE;
                    req_d     = 1'b0;
                    bus_we_d  = 1'b0;
                    be_d      = 2'b00;
                    bus_err_d = 1'b1;
                    rbuf_d    = 16'hFFFF;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            DONE: begin
                if (!we_q) begin
                    rdata_d = rbuf_q;
                end
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            byt_q       <= 1'b0;
            lane_q      <= 1'b0;
            split_q     <= 1'b0;
            wdata_hi_q  <= 8'h00;
            cnt_q       <= 8'h00;
            rbuf_q      <= 16'h0000;
            rdata_q     <= 16'h0000;
            req_q       <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 15'h0000;
            be_q        <= 2'b00;
            bus_wdata_q <= 16'h0000;
            bus_err_q   <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge _d values.
            state_q     <= state_d;
            we_q        <= we_d;
            byt_q       <= byt_d;
            lane_q      <= lane_d;
            split_q     <= split_d;
            wdata_hi_q  <= wdata_hi_d;
            cnt_q       <= cnt_d;
            rbuf_q      <= rbuf_d;
            rdata_q     <= rdata_d;
            req_q       <= req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            be_q        <= be_d;
            bus_wdata_q <= bus_wdata_d;
            bus_err_q   <= bus_err_d;
            misalign_q  <= misalign_d;
        end
    end

endmodule

// File: doc/mem_port.md
# mem_port

Data-memory access stage directly downstream of the control-signal generator. It consumes the execute-phase memory strobes (`rd_mem`, `wr_mem`, `byt`) together with the byte address and store data, and turns them into request/acknowledge transactions on a 16-bit word-organised memory bus with byte enables. While a transaction is in flight it raises `stall`, which freezes the phase sequencer. It returns read data to the stack datapath.

## Interface
Parameters:
- `TIMEOUT`, default 255: bus cycles spent waiting for `mem_ack` before the access is aborted. Range 1..255.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `rd_mem` in 1: read strobe from the control-signal generator. Held asserted while `stall`=1.
- `wr_mem` in 1: write strobe. Held asserted while `stall`=1.
- `byt` in 1: 1 = byte access, 0 = word access.
- `addr` in 16: byte address.
- `wdata` in 16: store data. For byte stores only bits [7:0] are used.
- `rdata` out 16: load result. Byte loads are zero-extended. Holds its value until the next read completes.
- `stall` out 1: combinational; freezes the phase sequencer.
- `bus_err` out 1: one-cycle pulse when a timeout abort occurs.
- `misalign` out 1: one-cycle pulse on an odd-address word access (only when `UNALIGNED_EN` is undefined).
- `mem_req` out 1: bus request, registered.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 15: word address.
- `mem_be` out 2: byte enables. Bit 1 = bits [15:8], the odd byte.
- `mem_wdata` out 16: bus write data.
- `mem_rdata` in 16: bus read data. Valid in the cycle where `mem_ack`=1.
- `mem_ack` in 1: completes the current request. May be asserted in the same cycle as `mem_req`.

## Operation
- Memory is little-endian: byte at address `a` sits in word `a>>1`, lane `a[0]`.
- `start` = (`rd_mem` | `wr_mem`) in IDLE. If both strobes are asserted, write wins and no read is performed.
- The FSM has four states: IDLE, ACC1, ACC2, DONE.
- **IDLE:**
  - On `start`: latch `addr`, `wdata`, `byt`, `we`; decide `split` (see below); load bus fields for the first beat; go to ACC1.
  - Otherwise stay in IDLE.
- **ACC1 / ACC2:**
  - `mem_req`=1. All bus fields stay stable until `mem_ack`.
  - On `mem_ack`: capture read lanes.
  - From ACC1: go to ACC2 if `split`, else DONE. From ACC2: go to DONE.
  - The timeout counter reloads on entry to each ACC state. If it expires: deassert `mem_req`, pulse `bus_err`, load `rdata`=16'hFFFF for reads, go to DONE.
- **DONE:** `rdata` is updated for reads; go to IDLE.
- `stall` = (IDLE & `start`) | ACC1 | ACC2. It is 0 in DONE.
- Lane mapping:
  - Aligned word: `be`=2'b11. `wdata` passes through. `rdata`=`mem_rdata`.
  - Byte: `be`=`addr[0]` ? 2'b10 : 2'b01. `mem_wdata`={`wdata[7:0]`, `wdata[7:0]`}. `rdata`={8'h00, selected lane}.
  - Split word (odd address, `UNALIGNED_EN`):
    - ACC1: word `a>>1`, `be`=2'b10, upper lane = `wdata[7:0]`; `rdata[7:0]` ← `mem_rdata[15:8]`.
    - ACC2: word `(a>>1)+1` modulo 2^15, `be`=2'b01, lower lane = `wdata[15:8]`; `rdata[15:8]` ← `mem_rdata[7:0]`.
- `mem_ack` while `mem_req`=0 is ignored.
- `rst` forces IDLE immediately. Any in-flight access is discarded with no completion.
- Reset values: `rdata`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_be`=0, `mem_wdata`=0, `bus_err`=0, `misalign`=0. `stall`=0 while the strobes are low.

## Timing
- Start cycle is T0; `stall`=1 combinationally in T0.
- `mem_req` rises at T1.
- Zero-wait memory:
  - Aligned access: `mem_ack` at T1, DONE at T2, `stall`=0 at T2. The phase sequencer advances at the end of T2. `rdata` is valid from T3.
  - Split access: ACC2 at T2, DONE at T3.
- Each wait cycle on `mem_ack` adds one cycle.
- Timeout case: `mem_req` stays high for `TIMEOUT` cycles in that state. `bus_err` is high during the first DONE cycle.
- The control side deasserts the strobes after the DONE cycle. A strobe still high in IDLE starts a new access.

## Configuration
- `MEM_PORT_UNALIGNED_EN` defined:
  - An odd-address word access splits into two bus beats as above.
  - `misalign` is tied to 0.
- Undefined:
  - `addr[0]` is forced to 0 for word accesses, giving a single beat.
  - `misalign` pulses for one cycle at T1.

## Test plan
- Word read at 0x0010, `mem_rdata`=0xBEEF, zero wait → `mem_addr`=0x0008, `be`=2'b11, `stall` high T0–T1, `rdata`=0xBEEF.
- Byte write of 0x5A at 0x0021 → `mem_addr`=0x0010, `be`=2'b10, `mem_wdata`=0x5A5A, `mem_we`=1 for one beat.
- Byte read at 0x0021 with `mem_rdata`=0x1234, 3 wait cycles → `rdata`=0x0012, `stall` high for 5 cycles.
- With `MEM_PORT_UNALIGNED_EN`, word read at 0xFFFF → beats to word 0x7FFF `be`=2'b10 then word 0x0000 `be`=2'b01. With returns 0xAB00 and 0x00CD, `rdata`=0xCDAB.
- `mem_ack` never arrives, `TIMEOUT`=4 → `mem_req` high 4 cycles, `bus_err` pulse, `rdata`=0xFFFF, `stall` drops.
- Assert `rst` during ACC1 → `mem_req`, `stall`, and all bus outputs 0 immediately. The next access starts cleanly.
